morph_frame_sink: RTL and testbench

- Downstream stage of the 3x3 bit-serial binary morphology filter (row width 256).
- Consumes the filter's 1-bit `out` stream and realigns it to pixel coordinates by compensating the filter's fixed latency.
- Masks the invalid frame border produced by the filter's line-buffer wrap.
- Emits a qualified pixel stream (valid/col/row/eof) and a per-frame foreground pixel count for the readout logic.

---
 rtl/morph_frame_sink.sv | 127 ++++++++++++
 tb/tb_morph_frame_sink.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/morph_frame_sink.sv
// morph_frame_sink: realigns the 3x3 morphology filter output stream to
// pixel coordinates, masks the wrap border and counts foreground pixels.
module morph_frame_sink #(
  parameter int   WIDTH      = 256,
  parameter int   HEIGHT     = 256,
  parameter int   LAT        = 257,
  parameter logic BORDER_VAL = 1'b0,
  parameter int   CW         = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof,
  input  logic          pix_in,
  output logic          pix_out,
  output logic          pix_valid,
  output logic [7:0]    col,
  output logic [7:0]    row,
  output logic          eof,
  output logic [CW-1:0] fg_count,
  output logic          count_valid
);

  localparam int DW = (LAT > 1) ? $clog2(LAT + 1) : 1;

  localparam logic [7:0]    XMAX    = 8'(WIDTH - 1);
  localparam logic [7:0]    YMAX    = 8'(HEIGHT - 1);
  localparam logic [DW-1:0] DLAST   = DW'(LAT - 1);
  localparam logic [CW-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] dly;
  logic [7:0]    cx;
  logic [7:0]    cy;
  logic [CW-1:0] acc;

  logic on_border;
  logic last_px;
  logic masked;

  // Position of the pixel sampled this edge decides masking and frame end.
  assign on_border = (cx == 8'd0) || (cx == XMAX) ||
                     (cy == 8'd0) || (cy == YMAX);
  assign last_px   = (cx == XMAX) && (cy == YMAX);
  assign masked    = on_border ? BORDER_VAL : pix_in;

  // Frame FSM: wait out the filter latency, stream one frame, publish count.
  // The PRIME exit edge is chosen so pixel 0 is sampled LAT+1 edges after sof.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dly         <= '0;
      cx          <= '0;
      cy          <= '0;
      acc         <= '0;
      pix_out     <= 1'b0;
      pix_valid   <= 1'b0;
      col         <= '0;
      row         <= '0;
      eof         <= 1'b0;
      fg_count    <= '0;
      count_valid <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      eof         <= 1'b0;
      count_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sof) begin
            state <= PRIME;
            dly   <= '0;
          end
        end
        PRIME: begin
          if (sof) begin
            dly <= '0;
          end else if (dly == DLAST) begin
            state <= STREAM;
            cx    <= '0;
            cy    <= '0;
            acc   <= '0;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        STREAM: begin
          if (sof) begin
            state <= PRIME;
            dly   <= '0;
          end else begin
            pix_out   <= masked;
            pix_valid <= 1'b1;
            col       <= cx;
            row       <= cy;
            eof       <= last_px;
            if (masked && (acc != ACC_MAX)) begin
              acc <= acc + 1'b1;
            end
            if (cx == XMAX) begin
              cx <= '0;
              cy <= cy + 8'd1;
            end else begin
              cx <= cx + 8'd1;
            end
            if (last_px) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          fg_count    <= acc;
          count_valid <= 1'b1;
          dly         <= '0;
          state       <= sof ? PRIME : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_frame_sink.sv
// tb_morph_frame_sink: directed frames against small and default-size
// instances, with a scoreboard of expected aligned pixels.
module tb_morph_frame_sink;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int L  = 9;
  localparam int NP = W * H;
  localparam int CW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic pix = 1'b0;
  logic sof_c = 1'b0;
  logic pix_c = 1'b1;

  logic          pa, va, ea, cva;
  logic [7:0]    ca, ra;
  logic [CW-1:0] fga;
  logic          pb, vb, eb, cvb;
  logic [7:0]    cb, rb;
  logic [CW-1:0] fgb;
  logic          pc, vc, ec, cvc;
  logic [7:0]    cc, rc;
  logic [CW-1:0] fgc;

  always #5 clk = ~clk;

  morph_frame_sink #(
    .WIDTH(W), .HEIGHT(H), .LAT(L), .BORDER_VAL(1'b0), .CW(CW)
  ) u_a (
    .clk(clk), .rst(rst), .sof(sof), .pix_in(pix),
    .pix_out(pa), .pix_valid(va), .col(ca), .row(ra), .eof(ea),
    .fg_count(fga), .count_valid(cva)
  );

  morph_frame_sink #(
    .WIDTH(W), .HEIGHT(H), .LAT(L), .BORDER_VAL(1'b1), .CW(CW)
  ) u_b (
    .clk(clk), .rst(rst), .sof(sof), .pix_in(pix),
    .pix_out(pb), .pix_valid(vb), .col(cb), .row(rb), .eof(eb),
    .fg_count(fgb), .count_valid(cvb)
  );

  morph_frame_sink u_c (
    .clk(clk), .rst(rst), .sof(sof_c), .pix_in(pix_c),
    .pix_out(pc), .pix_valid(vc), .col(cc), .row(rc), .eof(ec),
    .fg_count(fgc), .count_valid(cvc)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [CW-1:0] last_a = '0;
  logic [CW-1:0] last_b = '0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] c;
    logic       pa;
    logic       pb;
    logic       e;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int p);
    int r;
    int c;
    r = p / W;
    c = p % W;
    if (pat == 0) return 1'b1;
    return ((r + c) % 2) == 1;
  endfunction

  // stop_p < 0: full frame; otherwise a new sof lands on pixel stop_p.
  task automatic run_frame(input int pat, input int stop_p,
                           input int exp_a, input int exp_b);
    int   kend, p, r, c;
    logic v, ev, ecv, bd;
    exp_t e;
    kend = (stop_p < 0) ? L + NP + 3 : L + stop_p + 6;
    @(posedge clk);
    #1 sof = 1'b1;
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk);
      #1;
      sof = (stop_p >= 0) && (k == L + stop_p);
      p = k - L;
      if (p >= 0 && p < NP && (stop_p < 0 || p < stop_p)) begin
        r = p / W;
        c = p % W;
        v = pat_bit(pat, p);
        bd = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
        e.r = 8'(r);
        e.c = 8'(c);
        e.pa = bd ? 1'b0 : v;
        e.pb = bd ? 1'b1 : v;
        e.e = (p == NP - 1);
        sb.push_back(e);
      end else begin
        v = 1'($urandom);
      end
      pix = v;
      @(negedge clk);
      ev = (k >= L + 1) && (k <= L + NP) &&
           (stop_p < 0 || k <= L + stop_p);
      chk("pix_valid", va, ev);
      chk("pix_valid_b", vb, ev);
      if (ev && sb.size() > 0) begin
        e = sb.pop_front();
        chk("pix_out", pa, e.pa);
        chk("pix_out_b", pb, e.pb);
        chk("col", ca, e.c);
        chk("row", ra, e.r);
        chk("col_b", cb, e.c);
        chk("row_b", rb, e.r);
        chk("eof", ea, e.e);
        chk("eof_b", eb, e.e);
      end else begin
        chk("eof_idle", ea, 0);
      end
      ecv = (stop_p < 0) && (k == L + NP + 1);
      chk("count_valid", cva, ecv);
      chk("count_valid_b", cvb, ecv);
      if (ecv) begin
        last_a = CW'(exp_a);
        last_b = CW'(exp_b);
      end
      chk("fg_count", fga, last_a);
      chk("fg_count_b", fgb, last_b);
    end
    sof = 1'b0;
  endtask

  initial begin
    int first;
    bit done;

    repeat (3) @(negedge clk);
    chk("rst_valid", va, 0);
    chk("rst_fg", fga, 0);
    chk("rst_cv", cva, 0);
    chk("rst_eof", ea, 0);
    chk("rst_valid_c", vc, 0);
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("idle_valid", va, 0);
    end

    run_frame(0, -1, 12, 32);
    run_frame(1, -1, 6, 26);
    run_frame(0, 20, 0, 0);
    run_frame(0, -1, 12, 32);

    @(posedge clk);
    #1 sof = 1'b1;
    @(posedge clk);
    #1 sof = 1'b0;
    repeat (L + 10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", va, 0);
    chk("midrst_fg", fga, 0);
    chk("midrst_fg_b", fgb, 0);
    chk("midrst_cv", cva, 0);
    last_a = '0;
    last_b = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_valid", va, 0);
      chk("post_rst_cv", cva, 0);
    end
    run_frame(1, -1, 6, 26);

    @(posedge clk);
    #1 sof_c = 1'b1;
    @(posedge clk);
    #1 sof_c = 1'b0;
    first = -1;
    done = 1'b0;
    for (int k = 1; k <= 70000; k++) begin
      @(posedge clk);
      #1;
      if (vc && first < 0) begin
        first = k;
        chk("c_first_edge", first, 258);
        chk("c_first_col", cc, 0);
        chk("c_first_row", rc, 0);
      end
      if (ec) begin
        chk("c_eof_col", cc, 255);
        chk("c_eof_row", rc, 255);
      end
      if (cvc) begin
        chk("c_fg_count", fgc, 64516);
        chk("c_done_edge", k, 258 + 65536);
        done = 1'b1;
        break;
      end
    end
    chk("c_count_seen", 32'(done), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
